// File: rtl/register_writeback_queue.sv
// Register file write-back queue.
// Buffers up to two result writes per cycle (primary, secondary) in an in-order FIFO and
// drains one write per cycle into a registered register-file write port. Decode-stage read
// ids are forwarded the newest pending value still in the queue or output register.
// Optional trace output is enabled by defining WRITEBACK_TRACE_EN.
module register_writeback_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  primaryValid,
  output logic                  primaryReady,
  input  logic [4:0]            primaryId,
  input  logic [DATA_WIDTH-1:0] primaryData,
  input  logic [DATA_WIDTH-1:0] primaryPc,
  input  logic                  secondaryValid,
  output logic                  secondaryReady,
  input  logic [4:0]            secondaryId,
  input  logic [DATA_WIDTH-1:0] secondaryData,
  input  logic [DATA_WIDTH-1:0] secondaryPc,
  output logic                  writeEnabled,
  output logic [4:0]            writeId,
  output logic [DATA_WIDTH-1:0] dataWrite,
  output logic [DATA_WIDTH-1:0] programCounterWrite,
  input  logic [4:0]            readId1,
  input  logic [4:0]            readId2,
  output logic                  forwardHit1,
  output logic                  forwardHit2,
  output logic [DATA_WIDTH-1:0] forwardData1,
  output logic [DATA_WIDTH-1:0] forwardData2,
  output logic                  empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]       headPtr;
  logic [PtrW-1:0]       tailPtr;
  logic [CntW-1:0]       count;
  logic [4:0]            memId   [DEPTH];
  logic [DATA_WIDTH-1:0] memData [DEPTH];
  logic [DATA_WIDTH-1:0] memPc   [DEPTH];

  logic                  doPop;
  logic                  pushPrimary;
  logic                  pushSecondary;
  logic [CntW-1:0]       freeSlots;
  logic [PtrW-1:0]       secondaryPtr;
  logic [PtrW-1:0]       fwdIdx;

  // Handshake and slot accounting; the head pop frees a slot in the same cycle.
  always_comb begin
    doPop          = (count != '0);
    freeSlots      = CntW'(DEPTH) - count + CntW'(doPop);
    primaryReady   = (freeSlots >= CntW'(1));
    pushPrimary    = primaryValid && primaryReady && (primaryId != 5'd0);
    secondaryReady = pushPrimary ? (freeSlots >= CntW'(2)) : (freeSlots >= CntW'(1));
    pushSecondary  = secondaryValid && secondaryReady && (secondaryId != 5'd0);
    // Secondary lands behind the primary so it is the younger entry.
    secondaryPtr   = tailPtr + PtrW'(pushPrimary);
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      headPtr <= headPtr + PtrW'(doPop);
      tailPtr <= tailPtr + PtrW'(pushPrimary) + PtrW'(pushSecondary);
      count   <= count - CntW'(doPop) + CntW'(pushPrimary) + CntW'(pushSecondary);
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clock) begin
    if (pushPrimary) begin
      memId[tailPtr]   <= primaryId;
      memData[tailPtr] <= primaryData;
      memPc[tailPtr]   <= primaryPc;
    end
    if (pushSecondary) begin
      memId[secondaryPtr]   <= secondaryId;
      memData[secondaryPtr] <= secondaryData;
      memPc[secondaryPtr]   <= secondaryPc;
    end
  end

  // Registered register-file write port; fields hold when no write is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      writeEnabled        <= 1'b0;
      writeId             <= '0;
      dataWrite           <= '0;
      programCounterWrite <= '0;
    end else if (doPop) begin
      writeEnabled        <= 1'b1;
      writeId             <= memId[headPtr];
      dataWrite           <= memData[headPtr];
      programCounterWrite <= memPc[headPtr];
    end else begin
      writeEnabled        <= 1'b0;
    end
  end

  // Newest-value forwarding: output register is oldest, later FIFO offsets override.
  always_comb begin
    forwardHit1  = 1'b0;
    forwardHit2  = 1'b0;
    forwardData1 = '0;
    forwardData2 = '0;
    fwdIdx       = '0;
    if (writeEnabled && (readId1 != 5'd0) && (writeId == readId1)) begin
      forwardHit1  = 1'b1;
      forwardData1 = dataWrite;
    end
    if (writeEnabled && (readId2 != 5'd0) && (writeId == readId2)) begin
      forwardHit2  = 1'b1;
      forwardData2 = dataWrite;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwdIdx = headPtr + PtrW'(i);
      if ((CntW'(i) < count) && (readId1 != 5'd0) && (memId[fwdIdx] == readId1)) begin
        forwardHit1  = 1'b1;
        forwardData1 = memData[fwdIdx];
      end
      if ((CntW'(i) < count) && (readId2 != 5'd0) && (memId[fwdIdx] == readId2)) begin
        forwardHit2  = 1'b1;
        forwardData2 = memData[fwdIdx];
      end
    end
  end

  assign empty = (count == '0) && !writeEnabled;

`ifdef WRITEBACK_TRACE_EN
  // Trace of enqueues, drains and dropped r0 writes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (pushPrimary) begin
        $display("WB: Enq @0x%h: r%02d <= 0x%h", primaryPc, primaryId, primaryData);
      end else if (primaryValid && primaryReady) begin
        $display("WB: Drop @0x%h", primaryPc);
      end
      if (pushSecondary) begin
        $display("WB: Enq @0x%h: r%02d <= 0x%h", secondaryPc, secondaryId, secondaryData);
      end else if (secondaryValid && secondaryReady) begin
        $display("WB: Drop @0x%h", secondaryPc);
      end
      if (doPop) begin
        $display("WB: Drain @0x%h: r%0d <= 0x%h", memPc[headPtr], memId[headPtr],
                 memData[headPtr]);
      end
    end
  end
`else
  // Trace disabled: no simulation-only logic.
`endif

endmodule

// File: tb/tb_register_writeback_queue.sv
// Self-checking bench for register_writeback_queue: a table of single-cycle vectors plus
// hand-written multi-cycle sequences, with a scoreboard of expected register-file writes.
module tb_register_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          primaryValid, primaryReady, secondaryValid, secondaryReady;
  logic [4:0]    primaryId, secondaryId, writeId, readId1, readId2;
  logic [DW-1:0] primaryData, primaryPc, secondaryData, secondaryPc;
  logic          writeEnabled, forwardHit1, forwardHit2, empty;
  logic [DW-1:0] dataWrite, programCounterWrite, forwardData1, forwardData2;

  always #5 clock = ~clock;

  register_writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .primaryValid(primaryValid), .primaryReady(primaryReady), .primaryId(primaryId),
    .primaryData(primaryData), .primaryPc(primaryPc),
    .secondaryValid(secondaryValid), .secondaryReady(secondaryReady),
    .secondaryId(secondaryId), .secondaryData(secondaryData), .secondaryPc(secondaryPc),
    .writeEnabled(writeEnabled), .writeId(writeId), .dataWrite(dataWrite),
    .programCounterWrite(programCounterWrite),
    .readId1(readId1), .readId2(readId2),
    .forwardHit1(forwardHit1), .forwardHit2(forwardHit2),
    .forwardData1(forwardData1), .forwardData2(forwardData2),
    .empty(empty)
  );

  typedef struct {
    logic [4:0]  id;
    logic [31:0] data;
    logic [31:0] pc;
  } wr_t;

  typedef struct {
    logic        pv;
    logic [4:0]  pid;
    logic [31:0] pd;
    logic [31:0] ppc;
    logic        sv;
    logic [4:0]  sid;
    logic [31:0] sd;
    logic [31:0] spc;
    logic [4:0]  rid1;
    logic        eHit1;
    logic [31:0] eFd1;
    logic        eWe;
    logic [4:0]  eWid;
    logic        eEmpty;
  } vec_t;

  int   nVectors = 0;
  int   nFails   = 0;
  wr_t  sbq[$];
  logic popPending = 1'b0;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check readiness against the free-slot model, record writes.
  task automatic apply(input logic pv, input logic [4:0] pid, input logic [31:0] pd,
                       input logic [31:0] ppc, input logic sv, input logic [4:0] sid,
                       input logic [31:0] sd, input logic [31:0] spc,
                       input logic [4:0] r1, input logic [4:0] r2);
    int   sz;
    int   freeM;
    logic eRdyP;
    logic eRdyS;
    primaryValid   = pv;  primaryId   = pid; primaryData   = pd; primaryPc   = ppc;
    secondaryValid = sv;  secondaryId = sid; secondaryData = sd; secondaryPc = spc;
    readId1 = r1;
    readId2 = r2;
    #2;
    sz    = sbq.size();
    freeM = int'(DEPTH) - sz + ((sz > 0) ? 1 : 0);
    eRdyP = (freeM >= 1);
    eRdyS = (pv && eRdyP && pid != 5'd0) ? (freeM >= 2) : (freeM >= 1);
    check("primaryReady", primaryReady, eRdyP);
    check("secondaryReady", secondaryReady, eRdyS);
    popPending = (sz > 0);
    if (pv && eRdyP && pid != 5'd0) sbq.push_back('{id: pid, data: pd, pc: ppc});
    if (sv && eRdyS && sid != 5'd0) sbq.push_back('{id: sid, data: sd, pc: spc});
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    apply(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, r1, r2);
  endtask

  // Advance one clock and compare the write port against the scoreboard head.
  task automatic tick();
    wr_t e;
    @(posedge clock);
    #1;
    if (popPending) begin
      e = sbq.pop_front();
      check("writeEnabled", writeEnabled, 1'b1);
      check("writeId", writeId, e.id);
      check("dataWrite", dataWrite, e.data);
      check("programCounterWrite", programCounterWrite, e.pc);
    end else begin
      check("writeEnabled idle", writeEnabled, 1'b0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sbq.size() > 0; k++) begin
      idle(5'd0, 5'd0);
      tick();
    end
    nVectors++;
    if (sbq.size() != 0) begin
      nFails++;
      $display("FAIL drain timeout: %0d writes outstanding, expected 0", sbq.size());
    end
    idle(5'd0, 5'd0);
    tick();
  endtask

  task automatic doReset();
    reset = 1'b1;
    primaryValid = 1'b0; secondaryValid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    sbq.delete();
    popPending = 1'b0;
    check("reset writeEnabled", writeEnabled, 1'b0);
    check("reset writeId", writeId, 5'd0);
    check("reset dataWrite", dataWrite, 32'h0);
    check("reset programCounterWrite", programCounterWrite, 32'h0);
    check("reset empty", empty, 1'b1);
    check("reset forwardHit1", forwardHit1, 1'b0);
    check("reset forwardHit2", forwardHit2, 1'b0);
  endtask

  function automatic vec_t mk(input logic pv, input logic [4:0] pid, input logic [31:0] pd,
                              input logic [31:0] ppc, input logic sv, input logic [4:0] sid,
                              input logic [31:0] sd, input logic [31:0] spc,
                              input logic [4:0] rid1, input logic eHit1,
                              input logic [31:0] eFd1, input logic eWe,
                              input logic [4:0] eWid, input logic eEmpty);
    vec_t v;
    v.pv = pv; v.pid = pid; v.pd = pd; v.ppc = ppc;
    v.sv = sv; v.sid = sid; v.sd = sd; v.spc = spc;
    v.rid1 = rid1; v.eHit1 = eHit1; v.eFd1 = eFd1;
    v.eWe = eWe; v.eWid = eWid; v.eEmpty = eEmpty;
    return v;
  endfunction

  initial begin
    // pv pid pd ppc | sv sid sd spc | rid1 | hit1 fd1 (pre-edge) | we wid empty (post-edge)
    vecs[0] = mk(1, 5, 32'h11111111, 32'h00400000, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 32'h11111111, 1, 5, 0);
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 32'h11111111, 0, 5, 1);
    vecs[3] = mk(1, 3, 32'hA, 32'h00400010, 1, 4, 32'hB, 32'h00400014, 4, 0, 0, 0, 5, 0);
    vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 32'hB, 1, 3, 0);
    vecs[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 32'hA, 1, 4, 0);
    vecs[6] = mk(1, 0, 32'hDEAD, 32'h00400020, 1, 7, 32'h77, 32'h00400024, 0, 0, 0, 0, 4, 0);
    vecs[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 32'h77, 1, 7, 0);
    vecs[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 32'h77, 0, 7, 1);

    primaryValid = 1'b0; secondaryValid = 1'b0;
    primaryId = '0; secondaryId = '0; primaryData = '0; secondaryData = '0;
    primaryPc = '0; secondaryPc = '0; readId1 = 5'd5; readId2 = 5'd6;
    reset = 1'b1;
    @(posedge clock);
    #1;
    doReset();

    // Single-cycle table: basic latency, dual push ordering, r0 drop, forwarding sources.
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].pv, vecs[i].pid, vecs[i].pd, vecs[i].ppc,
            vecs[i].sv, vecs[i].sid, vecs[i].sd, vecs[i].spc, vecs[i].rid1, 5'd0);
      check($sformatf("vec%0d forwardHit1", i), forwardHit1, vecs[i].eHit1);
      if (vecs[i].eHit1) check($sformatf("vec%0d forwardData1", i), forwardData1, vecs[i].eFd1);
      tick();
      check($sformatf("vec%0d writeEnabled", i), writeEnabled, vecs[i].eWe);
      check($sformatf("vec%0d writeId", i), writeId, vecs[i].eWid);
      check($sformatf("vec%0d empty", i), empty, vecs[i].eEmpty);
    end

    // Fill to DEPTH by pushing two per cycle against a one-per-cycle drain.
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 5'(10 + 2 * k), 32'h1000 + 32'(k), 32'h00500000 + 32'(8 * k),
            1'b1, 5'(11 + 2 * k), 32'h2000 + 32'(k), 32'h00500004 + 32'(8 * k), 5'd0, 5'd0);
      tick();
    end
    apply(1'b1, 5'd16, 32'h1003, 32'h00500018, 1'b1, 5'd17, 32'h2003, 32'h0050001C,
          5'd0, 5'd0);
    check("full primaryReady", primaryReady, 1'b1);
    check("full secondaryReady", secondaryReady, 1'b0);
    tick();
    drain();

    // Same id queued twice: youngest value wins across FIFO and output register.
    apply(1'b1, 5'd9, 32'h1, 32'h00600000, 1'b1, 5'd9, 32'h2, 32'h00600004, 5'd9, 5'd9);
    tick();
    idle(5'd9, 5'd9);
    check("r9 forwardHit1 queued", forwardHit1, 1'b1);
    check("r9 forwardData1 queued", forwardData1, 32'h2);
    check("r9 forwardData2 queued", forwardData2, 32'h2);
    tick();
    idle(5'd9, 5'd9);
    check("r9 forwardData1 older in outreg", forwardData1, 32'h2);
    tick();
    idle(5'd9, 5'd9);
    check("r9 forwardData1 outreg", forwardData1, 32'h2);
    tick();
    idle(5'd9, 5'd9);
    check("r9 forwardHit1 drained", forwardHit1, 1'b0);
    check("r9 forwardHit2 drained", forwardHit2, 1'b0);
    tick();

    // Reset with three writes queued discards them.
    apply(1'b1, 5'd20, 32'h20, 32'h00700000, 1'b1, 5'd21, 32'h21, 32'h00700004, 5'd0, 5'd0);
    tick();
    apply(1'b1, 5'd22, 32'h22, 32'h00700008, 1'b1, 5'd23, 32'h23, 32'h0070000C, 5'd0, 5'd0);
    tick();
    idle(5'd22, 5'd23);
    check("prereset forwardData1", forwardData1, 32'h22);
    check("prereset forwardData2", forwardData2, 32'h23);
    check("prereset empty", empty, 1'b0);
    doReset();
    idle(5'd22, 5'd23);
    check("postreset forwardHit1", forwardHit1, 1'b0);
    tick();
    check("postreset empty", empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
    $finish;
  end

endmodule
